// File: rtl/memory_sequencer.sv
// Memory self-test sequencer: writes a constant array to consecutive word
// addresses, reads it back through a one-cycle read pipeline and reports the first mismatch.
module memory_sequencer #(
    parameter int word_size  = 32,
    parameter int addr_size  = 30,
    parameter int base_addr  = 1024,
    parameter int array_size = 4,
    parameter logic [word_size*array_size-1:0] array_content =
        128'h0D0C0B0A_0304EF00_01020304_ABCDEF00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [addr_size-1:0] addr,
    output logic [word_size-1:0] data_out,
    output logic                 write_en,
    input  logic [word_size-1:0] data_in,
    output logic                 done,
    output logic                 content_ok,
    output logic [7:0]           error_index
);

    typedef enum logic [1:0] {WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [addr_size-1:0] BASE = addr_size'(base_addr);
    localparam logic [7:0]           LAST = 8'(array_size - 1);

    state_t         state_p0, state_nxt;
    logic [7:0]     idx_p0, idx_nxt;
    logic           vld_p1, vld_nxt;
    logic [7:0]     cmp_idx_p1;
    logic           ok_q;
    logic [7:0]     err_idx_q;
    logic           mismatch;

    function automatic logic [word_size-1:0] element(input logic [7:0] i);
        return array_content[i*word_size +: word_size];
    endfunction

    always_comb begin
        state_nxt = state_p0;
        idx_nxt   = idx_p0;
        vld_nxt   = 1'b0;
        addr      = BASE;
        data_out  = '0;
        write_en  = 1'b0;
        done      = 1'b0;
        case (state_p0)
            WRITE: begin
                addr     = BASE + addr_size'(idx_p0);
                data_out = element(idx_p0);
                write_en = 1'b1;
                if (idx_p0 == LAST) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx_p0 + 8'd1;
                end
            end
            READ: begin
                addr    = BASE + addr_size'(idx_p0);
                vld_nxt = 1'b1;
                if (idx_p0 == LAST) begin
                    state_nxt = DRAIN;
                end else begin
                    idx_nxt = idx_p0 + 8'd1;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    done = 1'b1;
            default: state_nxt = WRITE;
        endcase
        // Outputs are forced while reset is held, not only after the first reset edge
        if (reset) begin
            addr     = BASE;
            data_out = '0;
            write_en = 1'b0;
            done     = 1'b0;
        end
    end

    assign mismatch    = vld_p1 && (data_in != element(cmp_idx_p1));
    assign content_ok  = reset | ok_q;
    assign error_index = reset ? 8'd0 : err_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0  <= WRITE;
            idx_p0    <= '0;
            vld_p1    <= 1'b0;
            ok_q      <= 1'b1;
            err_idx_q <= '0;
        end else if (enable) begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
            vld_p1   <= vld_nxt;
            if (mismatch) begin
                ok_q <= 1'b0;
                if (ok_q) begin
                    err_idx_q <= cmp_idx_p1;
                end
            end
        end
    end

    // p0 -> p1: index of the word whose read data arrives next enabled cycle
    always_ff @(posedge clk) begin
        if (enable) begin
            cmp_idx_p1 <= idx_p0;
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: a default instance and a 4-bit wrap-around instance
// share clock/reset/enable, each with its own ideal memory and transaction scoreboard.
module tb_memory_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        enable = 1'b0;

    logic [29:0] addr_a;
    logic [31:0] dout_a, din_a;
    logic        we_a, done_a, ok_a;
    logic [7:0]  err_a;

    logic [3:0]  addr_b;
    logic [31:0] dout_b, din_b;
    logic        we_b, done_b, ok_b;
    logic [7:0]  err_b;

    memory_sequencer dut_a (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr_a), .data_out(dout_a),
        .write_en(we_a), .data_in(din_a), .done(done_a), .content_ok(ok_a),
        .error_index(err_a)
    );

    memory_sequencer #(.addr_size(4), .base_addr(14), .array_size(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr_b), .data_out(dout_b),
        .write_en(we_b), .data_in(din_b), .done(done_b), .content_ok(ok_b),
        .error_index(err_b)
    );

    localparam logic [31:0] ELEM [4] = '{32'hABCDEF00, 32'h01020304, 32'h0304EF00, 32'h0D0C0B0A};
    localparam logic [3:0]  WRAP_ADDR [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    // Ideal memories, clock-enabled together with the sequencers
    logic [31:0] mem_a [0:2047];
    logic [31:0] mem_b [0:15];
    int flip1 = -1, flip2 = -1;

    always @(posedge clk) begin
        if (enable) begin
            if (we_a)
                mem_a[addr_a[10:0]] <= dout_a ^ {31'b0, (int'(addr_a) == flip1) || (int'(addr_a) == flip2)};
            else
                din_a <= mem_a[addr_a[10:0]];
            if (we_b)
                mem_b[addr_b] <= dout_b;
            else
                din_b <= mem_b[addr_b];
        end
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard entries: {write_en, addr(30), data_out(32)}
    typedef logic [62:0] xact_t;
    xact_t q_a[$];
    xact_t q_b[$];

    task automatic push_expected();
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 4; i++) begin
            q_a.push_back({1'b1, 30'(1024 + i), ELEM[i]});
            q_b.push_back({1'b1, 26'b0, WRAP_ADDR[i], ELEM[i]});
        end
        for (int i = 0; i < 4; i++) begin
            q_a.push_back({1'b0, 30'(1024 + i), 32'h0});
            q_b.push_back({1'b0, 26'b0, WRAP_ADDR[i], 32'h0});
        end
        q_a.push_back({1'b0, 30'd1024, 32'h0});
        q_b.push_back({1'b0, 26'b0, 4'd14, 32'h0});
    endtask

    always @(negedge clk) begin
        if (!reset && enable && !done_a) begin
            check("seq_a_avail", 80'(q_a.size() > 0), 80'd1);
            if (q_a.size() > 0) check("seq_a", 80'({we_a, addr_a, dout_a}), 80'(q_a.pop_front()));
        end
        if (!reset && enable && !done_b) begin
            check("seq_b_avail", 80'(q_b.size() > 0), 80'd1);
            if (q_b.size() > 0) check("seq_b", 80'({we_b, 26'b0, addr_b, dout_b}), 80'(q_b.pop_front()));
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state_a", 80'({we_a, addr_a, dout_a, done_a, ok_a, err_a}),
              80'({1'b0, 30'd1024, 32'h0, 1'b0, 1'b1, 8'h0}));
        check("reset_state_b", 80'({we_b, addr_b, dout_b, done_b, ok_b, err_b}),
              80'({1'b0, 4'd14, 32'h0, 1'b0, 1'b1, 8'h0}));
        push_expected();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run(input bit stall, input int stop_en, output int cyc);
        int en_cnt;
        int stall_left;
        en_cnt = 0;
        stall_left = stall ? 3 : 0;
        cyc = 0;
        while (!done_a && cyc < 100 && en_cnt != stop_en) begin
            if (stall_left > 0 && en_cnt == 5) begin
                enable = 1'b0;
                stall_left--;
                @(negedge clk);
                check("stall_hold", 80'({we_a, addr_a}), 80'({1'b0, 30'd1025}));
            end else begin
                enable = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (enable) en_cnt++;
        end
        enable = 1'b1;
    endtask

    typedef struct {
        string      name;
        int         f1;
        int         f2;
        bit         stall;
        int         exp_cycles;
        bit         exp_ok;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{"nominal",    -1,   -1,   1'b0, 9,  1'b1, 8'd0};
        vecs[1] = '{"mismatch",   1026, -1,   1'b0, 9,  1'b0, 8'd2};
        vecs[2] = '{"sticky",     1025, 1027, 1'b0, 9,  1'b0, 8'd1};
        vecs[3] = '{"stall",      -1,   -1,   1'b1, 12, 1'b1, 8'd0};
        vecs[4] = '{"first_word", 1024, -1,   1'b0, 9,  1'b0, 8'd0};
        vecs[5] = '{"last_word",  1027, -1,   1'b0, 9,  1'b0, 8'd3};

        for (int v = 0; v < 6; v++) begin
            flip1 = vecs[v].f1;
            flip2 = vecs[v].f2;
            apply_reset();
            run(vecs[v].stall, -1, cyc);
            check({vecs[v].name, "_cycles"}, 80'(cyc), 80'(vecs[v].exp_cycles));
            check({vecs[v].name, "_status_a"}, 80'({done_a, ok_a, err_a}),
                  80'({1'b1, vecs[v].exp_ok, vecs[v].exp_err}));
            check({vecs[v].name, "_status_b"}, 80'({done_b, ok_b, q_b.size() == 0}), 80'(3'b111));
            check({vecs[v].name, "_all_seen"}, 80'(q_a.size()), 80'd0);
            repeat (2) @(posedge clk);
            #1;
            check({vecs[v].name, "_done_hold"}, 80'({done_a, we_a, addr_a}), 80'({1'b1, 1'b0, 30'd1024}));
        end

        // Reset pulsed while index 2 is being read
        flip1 = -1;
        flip2 = -1;
        apply_reset();
        run(1'b0, 6, cyc);
        check("midreset_where", 80'({we_a, addr_a}), 80'({1'b0, 30'd1026}));
        reset = 1'b1;
        @(negedge clk);
        check("midreset_in_reset", 80'({we_a, addr_a, done_a}), 80'({1'b0, 30'd1024, 1'b0}));
        @(posedge clk); #1;
        @(posedge clk); #1;
        push_expected();
        reset = 1'b0;
        run(1'b0, -1, cyc);
        check("midreset_cycles", 80'(cyc), 80'd9);
        check("midreset_status", 80'({done_a, ok_a, err_a, q_a.size() == 0}), 80'({1'b1, 1'b1, 8'd0, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 SHALL have parameter word_size, default 32, data bus width in bits.
REQ-002 SHALL have parameter addr_size, default 30, word-address width in bits.
REQ-003 SHALL have parameter base_addr, default 1024, word address of the first array element.
REQ-004 SHALL have parameter array_size, default 4, number of words written and read back (1..256).
REQ-005 SHALL have parameter array_content, default 128'h0D0C0B0A_0304EF00_01020304_ABCDEF00, packed words; element i = array_content[i*word_size +: word_size].
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1, advance when high; freeze all state and outputs when low.
REQ-009 SHALL have port addr, output, addr_size, word address driven to memory.
REQ-010 SHALL have port data_out, output, word_size, write data.
REQ-011 SHALL have port write_en, output, 1, write strobe for the current addr/data_out.
REQ-012 SHALL have port data_in, input, word_size, read data, valid one cycle after addr is driven with write_en low.
REQ-013 SHALL have port done, output, 1, sequence finished.
REQ-014 SHALL have port content_ok, output, 1, all read-back words matched; meaningful only when done=1.
REQ-015 SHALL have port error_index, output, 8, index of the first mismatching word.

Function
REQ-016 SHALL implement states WRITE, READ, DRAIN, DONE with an 8-bit index counter idx.
REQ-017 SHALL, in WRITE, drive addr=base_addr+idx, data_out=element idx, write_en=1, one word per enabled cycle.
REQ-018 SHALL move WRITE->READ with idx cleared after the cycle that writes element array_size-1.
REQ-019 SHALL, in READ, drive addr=base_addr+idx, write_en=0, data_out=0, one address per enabled cycle.
REQ-020 SHALL pipeline reads: in each enabled cycle after a read issue, compare data_in with the element issued in the previous enabled cycle.
REQ-021 SHALL move READ->DRAIN after issuing index array_size-1; DRAIN performs the last compare and moves to DONE.
REQ-022 SHALL, in DONE, hold write_en=0, done=1, addr=base_addr; remain in DONE until reset.
REQ-023 SHALL, on a mismatch, clear content_ok, and record error_index only if no earlier mismatch occurred (sticky, first error kept).
REQ-024 SHALL compute addr as base_addr+idx truncated to addr_size bits (wrap-around modulo 2^addr_size).
REQ-025 SHALL, when enable is low, hold state, idx, addr, data_out, write_en and the pending compare; the compare resumes in the next enabled cycle.
REQ-026 SHALL produce a total of 2*array_size+1 enabled cycles from reset release to done=1.

Reset
REQ-027 SHALL, while reset=1, force state=WRITE, idx=0, write_en=0, done=0, content_ok=1, error_index=0, addr=base_addr, data_out=0.
REQ-028 SHALL abort any in-progress sequence on reset, including mid-write, mid-read or in DONE, and restart from WRITE index 0.
REQ-029 SHALL assert its first write (element 0) in the first enabled cycle after reset is released.

Verification
REQ-030 SHALL verify nominal run: defaults, ideal 1-cycle memory, enable=1 -> writes 0xABCDEF00,0x01020304,0x0304EF00,0x0D0C0B0A to 1024..1027, reads 1024..1027, done=1 nine cycles after reset release, content_ok=1.
REQ-031 SHALL verify mismatch: memory corrupts word 1026 to 0x0304EF01 -> done=1, content_ok=0, error_index=2.
REQ-032 SHALL verify first-error sticky: words 1025 and 1027 corrupted -> content_ok=0, error_index=1.
REQ-033 SHALL verify stall: enable low for 3 cycles during READ of index 1 -> addr held at 1025, no extra writes, done after 12 cycles, content_ok=1.
REQ-034 SHALL verify reset mid-sequence: reset pulsed during READ index 2 -> write_en=0 during reset, sequence restarts writing 0xABCDEF00 to 1024, content_ok=1 at finish.
REQ-035 SHALL verify wrap: addr_size=4, base_addr=14, array_size=4 -> addresses 14,15,0,1 written and read back, content_ok=1.
